// File: rtl/pe_hl_acc.sv
// Hidden-layer neuron accumulator: bias + sum of N_IN products, then ReLU,
// round-half-up, right-shift and saturate to a uint8 activation.
module pe_hl_acc #(
    parameter int N_IN  = 784,
    parameter int SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] product,
    input  logic [31:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [31:0] out_acc
);

    typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

    localparam logic [15:0] LAST = 16'(N_IN - 1);
    // Half an LSB of the shifted result; collapses to 0 when SHIFT == 0.
    localparam logic [32:0] RND  = (33'd1 << SHIFT) >> 1;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic signed [31:0] acc_q, acc_d;
    logic [7:0]         out_data_q, out_data_d;
    logic signed [31:0] out_acc_q, out_acc_d;

    function automatic logic [7:0] requant(input logic signed [31:0] a);
        logic [32:0] r;
        if (a < 0) begin
            return 8'd0;
        end
        r = ({1'b0, a} + RND) >> SHIFT;
        return (r > 33'd255) ? 8'd255 : r[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            cnt_q      <= 16'd0;
            acc_q      <= 32'sd0;
            out_data_q <= 8'd0;
            out_acc_q  <= 32'sd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_acc_q  <= out_acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    // Bias is folded in with the first product of the frame.
                    acc_d = (cnt_q == 16'd0) ? (bias + product) : (acc_q + product);
                    if (cnt_q == LAST) begin
                        cnt_d   = 16'd0;
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            FIN: begin
                out_acc_d  = acc_q;
                out_data_d = requant(acc_q);
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_acc   = out_acc_q;

endmodule
